// File: rtl/demux_1_to_8_stream_if.sv
// Stream interface for demux_1_to_8_stream: one input beat channel and eight output lanes.
// out_count exists only when DEMUX_COUNT_EN is defined.
interface demux_1_to_8_stream_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CNT_WIDTH  = 16
);
  logic [DATA_WIDTH-1:0]   in_data;
  logic [2:0]              in_select;
  logic                    in_bcast;
  logic                    in_valid;
  logic                    in_ready;
  logic [8*DATA_WIDTH-1:0] out_data;
  logic [7:0]              out_valid;
  logic [7:0]              out_ready;
`ifdef DEMUX_COUNT_EN
  logic [8*CNT_WIDTH-1:0]  out_count;
`endif

  if (CNT_WIDTH == 0) begin : g_cnt_width_check
    $error("CNT_WIDTH must be nonzero");
  end

  modport master (
`ifdef DEMUX_COUNT_EN
    input  out_count,
`endif
    output in_data, in_select, in_bcast, in_valid, out_ready,
    input  in_ready, out_data, out_valid
  );

  modport slave (
`ifdef DEMUX_COUNT_EN
    output out_count,
`endif
    input  in_data, in_select, in_bcast, in_valid, out_ready,
    output in_ready, out_data, out_valid
  );
endinterface

// File: rtl/demux_1_to_8_stream.sv
// Registered 1-to-8 stream demux with per-lane one-entry output registers and all-or-nothing broadcast.
// Optional per-lane saturating delivery counters are enabled by defining DEMUX_COUNT_EN.
module demux_1_to_8_stream #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input logic                   clk,
  input logic                   reset_n,
  demux_1_to_8_stream_if.slave  bus
);
  typedef enum logic {
    LANE_EMPTY = 1'b0,
    LANE_FULL  = 1'b1
  } lane_state_e;

  lane_state_e           state_q [8];
  lane_state_e           state_d [8];
  logic [DATA_WIDTH-1:0] data_q  [8];
  logic [7:0]            full;
  logic [7:0]            free;
  logic [7:0]            drain;
  logic [7:0]            load;
  logic                  accept;

  if (CNT_WIDTH == 0) begin : g_cnt_width_check
    $error("CNT_WIDTH must be nonzero");
  end

  always_comb begin
    full = '0;
    for (int unsigned k = 0; k < 8; k++) full[k] = (state_q[k] == LANE_FULL);
  end

  // A lane draining this edge can take a new beat on the same edge.
  assign free  = ~full | bus.out_ready;
  assign drain = full & bus.out_ready;

  assign bus.in_ready = bus.in_bcast ? (&free) : free[bus.in_select];
  assign accept       = bus.in_valid && bus.in_ready;

  always_comb begin
    load = '0;
    if (accept) load = bus.in_bcast ? 8'hFF : (8'd1 << bus.in_select);
  end

  always_comb begin
    for (int unsigned k = 0; k < 8; k++) begin
      state_d[k] = state_q[k];
      if (load[k])       state_d[k] = LANE_FULL;
      else if (drain[k]) state_d[k] = LANE_EMPTY;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned k = 0; k < 8; k++) begin
        state_q[k] <= LANE_EMPTY;
        data_q[k]  <= '0;
      end
    end else begin
      for (int unsigned k = 0; k < 8; k++) begin
        state_q[k] <= state_d[k];
        if (load[k]) data_q[k] <= bus.in_data;
      end
    end
  end

  always_comb begin
    bus.out_data = '0;
    for (int unsigned k = 0; k < 8; k++) bus.out_data[k*DATA_WIDTH +: DATA_WIDTH] = data_q[k];
  end

  assign bus.out_valid = full;

`ifdef DEMUX_COUNT_EN
  logic [CNT_WIDTH-1:0] cnt_q [8];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned k = 0; k < 8; k++) cnt_q[k] <= '0;
    end else begin
      for (int unsigned k = 0; k < 8; k++) begin
        if (drain[k] && (cnt_q[k] != '1)) cnt_q[k] <= cnt_q[k] + 1'b1;
      end
    end
  end

  always_comb begin
    bus.out_count = '0;
    for (int unsigned k = 0; k < 8; k++) bus.out_count[k*CNT_WIDTH +: CNT_WIDTH] = cnt_q[k];
  end
`endif
endmodule

// File: tb/tb_demux_1_to_8_stream.sv
// Self-checking bench for demux_1_to_8_stream: directed plan steps followed by constrained-random traffic.
// The reference model tracks each lane as "holding a beat or not" plus a saturating delivery tally.
module tb_demux_1_to_8_stream;
  localparam int unsigned DW = 8;
  localparam int unsigned CW = 2;

  logic clk = 1'b0;
  logic reset_n;

  demux_1_to_8_stream_if #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus ();

  demux_1_to_8_stream #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  bit          m_full [8];
  logic [7:0]  m_data [8];
  int unsigned m_cnt  [8];
  bit          last_acc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < 8; k++) begin
      m_full[k] = 1'b0;
      m_data[k] = '0;
      m_cnt[k]  = 0;
    end
  endtask

  function automatic bit model_ready();
    bit all_free;
    all_free = 1'b1;
    for (int k = 0; k < 8; k++) if (m_full[k] && !bus.out_ready[k]) all_free = 1'b0;
    if (bus.in_bcast) return all_free;
    return !m_full[bus.in_select] || bus.out_ready[bus.in_select];
  endfunction

  // Check outputs mid-cycle, then advance the model across the next rising edge.
  task automatic step(input string tag);
    bit         exp_ready;
    logic [7:0] exp_valid;
    @(negedge clk);
    exp_ready = model_ready();
    chk({tag, ".in_ready"}, 64'(bus.in_ready), 64'(exp_ready));
    for (int k = 0; k < 8; k++) exp_valid[k] = m_full[k];
    chk({tag, ".out_valid"}, 64'(bus.out_valid), 64'(exp_valid));
    for (int k = 0; k < 8; k++) begin
      if (m_full[k]) chk($sformatf("%s.lane%0d_data", tag, k), 64'(bus.out_data[k*DW +: DW]), 64'(m_data[k]));
`ifdef DEMUX_COUNT_EN
      chk($sformatf("%s.lane%0d_count", tag, k), 64'(bus.out_count[k*CW +: CW]), 64'(m_cnt[k]));
`endif
    end
    last_acc = bus.in_valid && exp_ready;
    for (int k = 0; k < 8; k++) begin
      bit delivered;
      bit target;
      delivered = m_full[k] && bus.out_ready[k];
      target    = last_acc && (bus.in_bcast || (int'(bus.in_select) == k));
      if (delivered && m_cnt[k] < (2**CW - 1)) m_cnt[k]++;
      if (target) begin
        m_full[k] = 1'b1;
        m_data[k] = bus.in_data;
      end else if (delivered) begin
        m_full[k] = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic [2:0] sel, input logic bc);
    bus.in_data   = d;
    bus.in_select = sel;
    bus.in_bcast  = bc;
    bus.in_valid  = 1'b1;
  endtask

  initial begin
    reset_n       = 1'b0;
    bus.out_ready = 8'h00;
    last_acc      = 1'b0;
    model_clear();
    send(8'hA5, 3'd3, 1'b0);

    // Reset with in_valid held high
    repeat (2) @(negedge clk);
    chk("reset.out_valid", 64'(bus.out_valid), 64'h00);
    chk("reset.in_ready", 64'(bus.in_ready), 64'h1);
    chk("reset.out_data", 64'(bus.out_data), 64'h0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    step("first_accept");
    bus.in_valid = 1'b0;
    step("first_visible");
    chk("first.out_valid_08", 64'(bus.out_valid), 64'h08);
    chk("first.lane3_A5", 64'(bus.out_data[3*DW +: DW]), 64'hA5);
    bus.out_ready = 8'h08;
    step("first_drain");
    bus.out_ready = 8'h00;

    // Back-pressure on lane 5
    send(8'h11, 3'd5, 1'b0);
    step("bp_first");
    send(8'h22, 3'd5, 1'b0);
    step("bp_stall0");
    step("bp_stall1");
    chk("bp.in_ready_low", 64'(bus.in_ready), 64'h0);
    chk("bp.lane5_hold", 64'(bus.out_data[5*DW +: DW]), 64'h11);
    bus.out_ready[5] = 1'b1;
    step("bp_release");
    bus.in_valid = 1'b0;
    chk("bp.lane5_second", 64'(bus.out_data[5*DW +: DW]), 64'h22);
    step("bp_second_out");
    step("bp_empty");

    // Streaming to each lane in turn
    bus.out_ready = 8'hFF;
    for (int i = 0; i < 8; i++) begin
      send(8'(i), 3'(i), 1'b0);
      step($sformatf("stream%0d", i));
    end
    bus.in_valid = 1'b0;
    step("stream_tail0");
    step("stream_tail1");

    // Broadcast gated by a stalled lane 2
    bus.out_ready = 8'h00;
    send(8'h77, 3'd2, 1'b0);
    step("bc_fill2");
    send(8'h5A, 3'd6, 1'b1);
    step("bc_blocked0");
    step("bc_blocked1");
    chk("bc.out_valid_only2", 64'(bus.out_valid), 64'h04);
    bus.out_ready = 8'h04;
    step("bc_release");
    bus.in_valid  = 1'b0;
    bus.out_ready = 8'h00;
    chk("bc.out_valid_all", 64'(bus.out_valid), 64'hFF);
    chk("bc.lane0_5A", 64'(bus.out_data[0 +: DW]), 64'h5A);
    chk("bc.lane7_5A", 64'(bus.out_data[7*DW +: DW]), 64'h5A);
    step("bc_hold");
    bus.out_ready = 8'hFF;
    step("bc_drain");
    bus.out_ready = 8'h00;

    // Simultaneous drain and load on lane 0
    send(8'h44, 3'd0, 1'b0);
    step("sdl_fill");
    send(8'h33, 3'd0, 1'b0);
    bus.out_ready = 8'h01;
    step("sdl_both");
    bus.in_valid  = 1'b0;
    bus.out_ready = 8'h00;
    chk("sdl.valid0", 64'(bus.out_valid[0]), 64'h1);
    chk("sdl.lane0_33", 64'(bus.out_data[0 +: DW]), 64'h33);
    step("sdl_hold");
    bus.out_ready = 8'hFF;
    step("sdl_drain");

    // Counter saturation on lane 7 from a clean reset
    @(negedge clk);
    reset_n = 1'b0;
    model_clear();
    @(posedge clk);
    #1;
    reset_n       = 1'b1;
    bus.out_ready = 8'h80;
    for (int i = 0; i < 5; i++) begin
      send(8'(8'hC0 + i), 3'd7, 1'b0);
      step($sformatf("cnt_beat%0d", i));
    end
    bus.in_valid = 1'b0;
    step("cnt_tail0");
    step("cnt_tail1");
`ifdef DEMUX_COUNT_EN
    chk("cnt.lane7_sat", 64'(bus.out_count[7*CW +: CW]), 64'd3);
    chk("cnt.lane0_zero", 64'(bus.out_count[0 +: CW]), 64'd0);
`endif

    // Random traffic; a blocked beat is held stable until accepted
    last_acc = 1'b0;
    for (int n = 0; n < 400; n++) begin
      if (n == 200) begin
        send(8'hEE, 3'd1, 1'b0);
        bus.out_ready = 8'h00;
        step("mid_fill");
        #2;
        reset_n = 1'b0;
        #1;
        chk("midreset.out_valid", 64'(bus.out_valid), 64'h00);
        chk("midreset.out_data", 64'(bus.out_data), 64'h0);
        model_clear();
        @(posedge clk);
        #1;
        reset_n      = 1'b1;
        bus.in_valid = 1'b0;
        last_acc     = 1'b0;
      end
      if (!bus.in_valid || last_acc) begin
        bus.in_valid  = ($urandom_range(0, 3) != 0);
        bus.in_data   = 8'($urandom);
        bus.in_select = 3'($urandom);
        bus.in_bcast  = ($urandom_range(0, 7) == 0);
      end
      bus.out_ready = 8'($urandom) | 8'($urandom);
      step("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
